// File: rtl/ysyx_23060180_pkg.sv
// ysyx_23060180_pkg: shared types and constants for the core memory bridge
package ysyx_23060180_pkg;
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} mem_bridge_state_t;
   localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        we;
   } mem_req_t;
   // reads are judged as word accesses; writes by their byte-enable shape
   function automatic logic misaligned(input logic we, input logic [31:0] addr, input logic [3:0] be);
      logic word_bad, half_bad;
      word_bad = (addr[1:0] != 2'b00) && (!we || be == 4'b1111);
      half_bad = we && addr[0] && (be == 4'b0011 || be == 4'b1100);
      return word_bad || half_bad;
   endfunction
endpackage

// File: rtl/ysyx_23060180_mem_bridge.sv
// ysyx_23060180_mem_bridge: strobe-to-valid/ready memory bridge with timeout; YSYX_23060180_MISALIGN_CHK_EN enables misalignment faults
module ysyx_23060180_mem_bridge
   import ysyx_23060180_pkg::*;
#(
   parameter int unsigned TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        core_rd,
   input  logic        core_wr,
   input  logic [31:0] core_addr,
   input  logic [31:0] core_wdata,
   input  logic [3:0]  core_wbit_en,
   output logic [31:0] core_rdata,
   output logic        core_stall,
   output logic        bus_err,
   output logic        m_req_valid,
   input  logic        m_req_ready,
   output logic        m_req_we,
   output logic [31:0] m_req_addr,
   output logic [31:0] m_req_wdata,
   output logic [3:0]  m_req_wstrb,
   input  logic        m_rsp_valid,
   input  logic [31:0] m_rsp_rdata
);
   mem_bridge_state_t state;
   mem_req_t          req;
   logic [7:0]        cnt;
   logic [31:0]       rdata_q;
   logic              err_q;
   logic              strobe, busy, expire, bad;
   assign strobe = core_rd | core_wr;
   assign busy   = (state == REQ) || (state == WAIT);
   // the cycle that would be the TIMEOUT-th in flight aborts, even if the memory answers in it
   assign expire = busy && (cnt == 8'(TIMEOUT - 1));
`ifdef YSYX_23060180_MISALIGN_CHK_EN
   assign bad = misaligned(core_wr, core_addr, core_wbit_en);
`else
   assign bad = 1'b0;
`endif
   assign core_stall  = (state == IDLE && strobe) || busy;
   assign m_req_valid = state == REQ;
   assign m_req_we    = req.we;
   assign m_req_addr  = req.addr;
   assign m_req_wdata = req.wdata;
   assign m_req_wstrb = req.wstrb;
   assign core_rdata  = rdata_q;
   assign bus_err     = err_q;
   // access sequencer: latch, issue, await response or timeout, then release the core for one cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         req     <= '0;
         cnt     <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state)
            IDLE: if (strobe) begin
               if (bad) begin
                  state   <= DONE;
                  err_q   <= 1'b1;
                  rdata_q <= ERR_DATA;
               end else begin
                  state <= REQ;
                  cnt   <= '0;
                  req   <= '{addr: core_addr, wdata: core_wdata,
                             wstrb: core_wr ? core_wbit_en : 4'b0000, we: core_wr};
               end
            end
            REQ, WAIT: begin
               cnt <= cnt + 8'd1;
               if (expire) begin
                  state   <= DONE;
                  err_q   <= 1'b1;
                  rdata_q <= ERR_DATA;
               end else if (state == REQ && m_req_ready) begin
                  state <= WAIT;
               end else if (state == WAIT && m_rsp_valid) begin
                  state   <= DONE;
                  rdata_q <= req.we ? rdata_q : m_rsp_rdata;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ysyx_23060180_mem_bridge.sv
// tb_ysyx_23060180_mem_bridge: randomized self-checking bench for the memory bridge
module tb_ysyx_23060180_mem_bridge;
   localparam int TO = 8;
   localparam logic [31:0] ERR = 32'hDEAD_BEEF;
   logic        clk = 1'b0, rst = 1'b1;
   logic        core_rd = 1'b0, core_wr = 1'b0;
   logic [31:0] core_addr = '0, core_wdata = '0;
   logic [3:0]  core_wbit_en = '0;
   logic [31:0] core_rdata;
   logic        core_stall, bus_err;
   logic        m_req_valid, m_req_we;
   logic        m_req_ready = 1'b0, m_rsp_valid = 1'b0;
   logic [31:0] m_req_addr, m_req_wdata, m_rsp_rdata = '0;
   logic [3:0]  m_req_wstrb;
   int          checks = 0, failures = 0;

   ysyx_23060180_mem_bridge #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
      .clk(clk), .rst(rst),
      .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_wbit_en(core_wbit_en),
      .core_rdata(core_rdata), .core_stall(core_stall), .bus_err(bus_err),
      .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_we(m_req_we),
      .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata), .m_req_wstrb(m_req_wstrb),
      .m_rsp_valid(m_rsp_valid), .m_rsp_rdata(m_rsp_rdata)
   );

   always #5 clk = ~clk;

   // one core access against a memory that accepts after d refused cycles and answers r cycles later
   task automatic access(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, input int d, input int r, input logic [31:0] rsp, input bit hold);
      int  total, lat, nreq, nwait;
      bit  err, acc, done;
      total = d + 1 + r;
      err   = total >= TO;
      lat   = err ? TO + 1 : total + 1;
      core_rd = rd; core_wr = wr; core_addr = addr; core_wdata = wd; core_wbit_en = be;
      #1;
      checks++;
      if (core_stall !== 1'b1) begin failures++; $display("FAIL stall_t0 got=%b exp=1", core_stall); end
      nreq = 0; nwait = 0; acc = 0; done = 0;
      for (int c = 1; c <= 300 && !done; c++) begin
         @(posedge clk); #1;
         m_req_ready = 1'b0; m_rsp_valid = 1'b0; m_rsp_rdata = $urandom;
         if (!core_stall) begin
            done = 1;
            checks++;
            if (c != lat) begin failures++; $display("FAIL latency got=%0d exp=%0d", c, lat); end
            checks++;
            if (bus_err !== err) begin failures++; $display("FAIL bus_err got=%b exp=%b", bus_err, err); end
            if (err || !wr) begin
               checks++;
               if (core_rdata !== (err ? ERR : rsp)) begin
                  failures++; $display("FAIL rdata got=%h exp=%h", core_rdata, err ? ERR : rsp);
               end
            end
            if (!hold) begin core_rd = 1'b0; core_wr = 1'b0; end
         end else if (m_req_valid) begin
            checks++;
            if ({m_req_we, m_req_addr, m_req_wdata, m_req_wstrb} !== {wr, addr, wd, wr ? be : 4'b0000}) begin
               failures++;
               $display("FAIL req_fields got=%b/%h/%h/%b exp=%b/%h/%h/%b", m_req_we, m_req_addr, m_req_wdata,
                        m_req_wstrb, wr, addr, wd, wr ? be : 4'b0000);
            end
            m_req_ready = (nreq == d);
            acc = acc | (nreq == d);
            nreq++;
         end else if (acc) begin
            m_rsp_valid = (nwait == r - 1);
            if (m_rsp_valid) m_rsp_rdata = rsp;
            nwait++;
         end
      end
      if (!done) begin failures++; $display("FAIL no_done got=stalled exp=done"); end
      @(posedge clk); #1;
      checks++;
      if (bus_err !== 1'b0 || m_req_valid !== 1'b0 || core_stall !== hold) begin
         failures++;
         $display("FAIL after_done got=err%b/val%b/stall%b exp=err0/val0/stall%b", bus_err, m_req_valid, core_stall, hold);
      end
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({m_req_valid, core_stall, bus_err, core_rdata, m_req_we, m_req_addr, m_req_wdata, m_req_wstrb} !== '0) begin
         failures++;
         $display("FAIL reset_state got=%b/%b/%b/%h/%h exp=all zero", m_req_valid, core_stall, bus_err, core_rdata, m_req_addr);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_plan_cases;
      access(1, 0, 32'h8000_0000, 32'h0, 4'h0, 0, 1, 32'h1234_5678, 0);
      access(0, 1, 32'h8000_0010, 32'hA5A5_A5A5, 4'b0011, 3, 1, 32'h0, 0);
      access(1, 1, 32'h8000_0020, 32'h5555_0000, 4'b1111, 1, 2, 32'h0, 0);
   endtask

   task automatic test_timeout;
      access(1, 0, 32'h8000_0100, 32'h0, 4'h0, 2, 4, 32'hCAFE_0001, 0);
      access(1, 0, 32'h8000_0104, 32'h0, 4'h0, 2, 5, 32'hCAFE_0002, 0);
      access(1, 0, 32'h8000_0108, 32'h0, 4'h0, 50, 1, 32'hCAFE_0003, 0);
      access(0, 1, 32'h8000_010C, 32'h1111_2222, 4'b1111, 0, 40, 32'h0, 0);
   endtask

   task automatic test_back_to_back;
      access(1, 0, 32'h8000_0200, 32'h0, 4'h0, 0, 1, 32'h0BAD_F00D, 1);
      access(1, 0, 32'h8000_0204, 32'h0, 4'h0, 0, 1, 32'h600D_CAFE, 0);
   endtask

   task automatic test_reset_mid;
      core_rd = 1'b1; core_addr = 32'h8000_0300;
      @(posedge clk); #1;
      m_req_ready = 1'b1;
      @(posedge clk); #1;
      m_req_ready = 1'b0;
      rst = 1'b1; core_rd = 1'b0;
      #1;
      checks++;
      if (m_req_valid !== 1'b0 || core_stall !== 1'b0) begin
         failures++; $display("FAIL reset_async got=val%b/stall%b exp=val0/stall0", m_req_valid, core_stall);
      end
      #2 rst = 1'b0;
      @(posedge clk); #1;
      m_rsp_valid = 1'b1; m_rsp_rdata = 32'h7777_7777;
      @(posedge clk); #1;
      m_rsp_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (m_req_valid !== 1'b0 || core_stall !== 1'b0 || bus_err !== 1'b0) begin
            failures++;
            $display("FAIL stray_rsp got=val%b/stall%b/err%b exp=val0/stall0/err0", m_req_valid, core_stall, bus_err);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_misalign;
`ifdef YSYX_23060180_MISALIGN_CHK_EN
      for (int k = 0; k < 2; k++) begin
         core_rd = (k == 0); core_wr = (k == 1);
         core_addr = (k == 0) ? 32'h8000_0002 : 32'h8000_0001;
         core_wbit_en = 4'b0011; core_wdata = 32'h1;
         #1;
         checks++;
         if (core_stall !== 1'b1) begin failures++; $display("FAIL mis_stall got=%b exp=1", core_stall); end
         @(posedge clk); #1;
         checks++;
         if (core_stall !== 1'b0 || bus_err !== 1'b1 || core_rdata !== ERR || m_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL mis_done got=stall%b/err%b/%h/val%b exp=stall0/err1/%h/val0", core_stall, bus_err, core_rdata, m_req_valid, ERR);
         end
         core_rd = 1'b0; core_wr = 1'b0;
         @(posedge clk); #1;
         checks++;
         if (bus_err !== 1'b0 || m_req_valid !== 1'b0) begin
            failures++; $display("FAIL mis_after got=err%b/val%b exp=err0/val0", bus_err, m_req_valid);
         end
      end
      access(0, 1, 32'h8000_0402, 32'hABCD_0000, 4'b1100, 0, 1, 32'h0, 0);
`else
      access(1, 0, 32'h8000_0002, 32'h0, 4'h0, 0, 1, 32'h2468_ACE0, 0);
`endif
   endtask

   task automatic test_random;
      for (int n = 0; n < 40; n++) begin
         logic rd, wr;
         logic [3:0] be;
         rd = 1'($urandom);
         wr = !rd | 1'($urandom);
         be = 4'($urandom_range(1, 15));
         access(rd, wr, $urandom & 32'hFFFF_FFFC, $urandom, be,
                int'($urandom_range(0, 4)), int'($urandom_range(1, 4)), $urandom, 0);
      end
   endtask

   initial begin
      test_reset;
      test_plan_cases;
      test_timeout;
      test_back_to_back;
      test_reset_mid;
      test_misalign;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
